pa_fpu_frbus_wb: RTL and testbench

//  Writeback buffer directly downstream of the FPU datapath EX2 stage.
//  - Captures each EX2 result (data, fflags, destination register) qualified by ex2_inst_wb.
//  - Queues results in a small FIFO and drains them to the FP register-file write port

---
 rtl/pa_fpu_frbus_wb.sv | 114 +++++++++++
 tb/tb_pa_fpu_frbus_wb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_fpu_frbus_wb.sv
// FPU writeback buffer between the EX2 stage and the FP register-file write port.
// Queues EX2 results (data, fflags, destination) in a small FIFO. Drains the head
// to the register file with a valid/ack handshake. Asserts a registered stall
// toward EX1 while keeping one slot in reserve. Accumulates sticky fflags as each
// entry retires.
module pa_fpu_frbus_wb #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic [DATA_W-1:0] dp_frbus_ex2_data,
  input  logic [4:0]        dp_frbus_ex2_fflags,
  input  logic              ex2_inst_wb,
  input  logic [4:0]        ctrl_frbus_ex2_dst_reg,
  input  logic              rf_frbus_wb_ack,
  output logic              frbus_rf_wb_vld,
  output logic [DATA_W-1:0] frbus_rf_wb_data,
  output logic [4:0]        frbus_rf_wb_reg,
  output logic              frbus_ctrl_stall,
  output logic              frbus_ctrl_empty,
  input  logic              cp0_fpu_fflags_wen,
  input  logic [4:0]        cp0_fpu_fflags_wdata,
  output logic [4:0]        fpu_cp0_fflags,
  output logic              frbus_ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [4:0]        fflags;
    logic [4:0]        dst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          push;
  logic          pop;
  logic          push_acc;
  logic          ovf;
  logic [4:0]    fflags_next;

  assign head     = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign push     = ex2_inst_wb;
  // An ack is meaningful only while a head entry is being presented.
  assign pop      = frbus_rf_wb_vld & rf_frbus_wb_ack;
  // A full FIFO still accepts a push when the head retires in the same cycle.
  assign push_acc = push & (~full | pop);
  assign ovf      = push & full & ~pop;

  // Head outputs read zero while empty so that stale storage is never exposed.
  assign frbus_rf_wb_vld  = (count != '0);
  assign frbus_ctrl_empty = (count == '0);
  assign frbus_rf_wb_data = frbus_rf_wb_vld ? head.data : '0;
  assign frbus_rf_wb_reg  = frbus_rf_wb_vld ? head.dst  : '0;

  // Next occupancy from the accepted push and the retiring pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_next = count;
    case ({push_acc, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Sticky flag update: a CSR write replaces the image, and the retiring entry's flags are always ORed in.
  always_comb begin
    fflags_next = fpu_cp0_fflags;
    if (cp0_fpu_fflags_wen) fflags_next = cp0_fpu_fflags_wdata;
    if (pop)                fflags_next = fflags_next | head.fflags;
  end

  // Entry storage is written on an accepted push.
  // NOTE: the storage array has no reset; the count gates every read, so an entry is never observed before it is written.
  always_ff @(posedge forever_cpuclk) begin
    if (push_acc) begin
      mem[wr_ptr] <= '{data:   dp_frbus_ex2_data,
                       fflags: dp_frbus_ex2_fflags,
                       dst:    ctrl_frbus_ex2_dst_reg};
    end
  end

  // Pointers, occupancy, registered stall, sticky flags and overflow error.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      frbus_ctrl_stall <= 1'b0;
      fpu_cp0_fflags   <= '0;
      frbus_ovf_err    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so that every update here sees pre-edge values.
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      count            <= count_next;
      // Stall one entry early: an instruction already past EX1 still finds a free slot.
      frbus_ctrl_stall <= (count_next >= CW'(DEPTH - 1));
      fpu_cp0_fflags   <= fflags_next;
      if (ovf) frbus_ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pa_fpu_frbus_wb.sv
// Directed and random checks of the FPU writeback buffer.
// Covers reset, latency, backpressure, full push+pop, fflags/CSR interplay and in-order retirement.
module tb_pa_fpu_frbus_wb;

  logic        clk = 1'b0;
  logic        cpurst;
  logic [31:0] ex2_data;
  logic [4:0]  ex2_fflags;
  logic        ex2_inst_wb;
  logic [4:0]  ex2_dst;
  logic        ack;
  logic        vld;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        stall;
  logic        empty;
  logic        fflags_wen;
  logic [4:0]  fflags_wdata;
  logic [4:0]  fflags;
  logic        ovf_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic [4:0]  fl;
  } item_t;

  item_t      q[$];
  logic [4:0] fl_model;

  pa_fpu_frbus_wb #(.DEPTH(2), .DATA_W(32)) dut (
    .forever_cpuclk         (clk),
    .cpurst                 (cpurst),
    .dp_frbus_ex2_data      (ex2_data),
    .dp_frbus_ex2_fflags    (ex2_fflags),
    .ex2_inst_wb            (ex2_inst_wb),
    .ctrl_frbus_ex2_dst_reg (ex2_dst),
    .rf_frbus_wb_ack        (ack),
    .frbus_rf_wb_vld        (vld),
    .frbus_rf_wb_data       (wb_data),
    .frbus_rf_wb_reg        (wb_reg),
    .frbus_ctrl_stall       (stall),
    .frbus_ctrl_empty       (empty),
    .cp0_fpu_fflags_wen     (fflags_wen),
    .cp0_fpu_fflags_wdata   (fflags_wdata),
    .fpu_cp0_fflags         (fflags),
    .frbus_ovf_err          (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] d, input logic [4:0] r, input logic [4:0] f);
    ex2_inst_wb = 1'b1;
    ex2_data    = d;
    ex2_dst     = r;
    ex2_fflags  = f;
  endtask

  task automatic pulse_reset();
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
  endtask

  initial begin
    cpurst       = 1'b1;
    ex2_data     = '0;
    ex2_fflags   = '0;
    ex2_inst_wb  = 1'b0;
    ex2_dst      = '0;
    ack          = 1'b0;
    fflags_wen   = 1'b0;
    fflags_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld",    vld,     1'b0);
    check("rst_empty",  empty,   1'b1);
    check("rst_stall",  stall,   1'b0);
    check("rst_fflags", fflags,  5'd0);
    check("rst_ovf",    ovf_err, 1'b0);
    check("rst_data",   wb_data, 32'd0);
    cpurst = 1'b0;

    // 1: reset mid-traffic with two entries queued
    drive_push(32'hAAAA0001, 5'd1, 5'b00001);
    step();
    drive_push(32'hAAAA0002, 5'd2, 5'b00010);
    step();
    ex2_inst_wb = 1'b0;
    check("t1_full_vld", vld, 1'b1);
    cpurst = 1'b1;
    #1;
    check("t1_vld",    vld,     1'b0);
    check("t1_empty",  empty,   1'b1);
    check("t1_stall",  stall,   1'b0);
    check("t1_fflags", fflags,  5'd0);
    check("t1_reg",    wb_reg,  5'd0);
    repeat (3) step();
    cpurst = 1'b0;
    ack    = 1'b1;
    step();
    check("t1_no_write", vld,    1'b0);
    check("t1_fl_after", fflags, 5'd0);

    // 2: single push with ack tied high
    drive_push(32'h3F800000, 5'd5, 5'b00001);
    #1;
    check("t2_no_bypass", vld, 1'b0);
    step();
    ex2_inst_wb = 1'b0;
    check("t2_vld",     vld,     1'b1);
    check("t2_reg",     wb_reg,  5'd5);
    check("t2_data",    wb_data, 32'h3F800000);
    check("t2_fl_hold", fflags,  5'd0);
    step();
    check("t2_fflags", fflags, 5'b00001);
    check("t2_empty",  empty,  1'b1);
    check("t2_stall",  stall,  1'b0);

    // 3: backpressure, third push dropped
    ack = 1'b0;
    drive_push(32'h11111111, 5'd1, 5'b00010);
    step();
    check("t3_stall_a", stall,   1'b1);
    check("t3_head_a",  wb_data, 32'h11111111);
    drive_push(32'h22222222, 5'd2, 5'b00100);
    step();
    check("t3_ovf_b",  ovf_err, 1'b0);
    check("t3_stall_b", stall,  1'b1);
    drive_push(32'h33333333, 5'd3, 5'b01000);
    step();
    ex2_inst_wb = 1'b0;
    check("t3_ovf_c",  ovf_err, 1'b1);
    check("t3_head_c", {wb_reg, wb_data}, {5'd1, 32'h11111111});
    ack = 1'b1;
    step();
    check("t3_ret_b",  {wb_reg, wb_data}, {5'd2, 32'h22222222});
    check("t3_fl_a",   fflags, 5'b00011);
    step();
    check("t3_empty",  empty,   1'b1);
    check("t3_fl_b",   fflags,  5'b00111);
    check("t3_stall0", stall,   1'b0);
    check("t3_ovf_st", ovf_err, 1'b1);

    // 4: full FIFO with simultaneous push and pop
    ack = 1'b0;
    pulse_reset();
    drive_push(32'h44444444, 5'd6, 5'b00001);
    step();
    drive_push(32'h55555555, 5'd7, 5'b00010);
    step();
    drive_push(32'h66666666, 5'd8, 5'b10000);
    ack = 1'b1;
    step();
    ex2_inst_wb = 1'b0;
    check("t4_ovf",   ovf_err, 1'b0);
    check("t4_head",  {wb_reg, wb_data}, {5'd7, 32'h55555555});
    check("t4_stall", stall,   1'b1);
    check("t4_fl1",   fflags,  5'b00001);
    step();
    check("t4_head_d", {wb_reg, wb_data}, {5'd8, 32'h66666666});
    check("t4_fl2",    fflags, 5'b00011);
    step();
    check("t4_empty", empty,   1'b1);
    check("t4_fl3",   fflags,  5'b10011);
    check("t4_ovf2",  ovf_err, 1'b0);

    // 5: CSR write colliding with a pop, then CSR alone, then queued flags untouched
    ack = 1'b0;
    drive_push(32'h77777777, 5'd9, 5'b10000);
    step();
    ex2_inst_wb  = 1'b0;
    fflags_wen   = 1'b1;
    fflags_wdata = 5'b00100;
    ack          = 1'b1;
    step();
    check("t5_collide", fflags, 5'b10100);
    ack          = 1'b0;
    fflags_wdata = 5'b00000;
    step();
    check("t5_csr0", fflags, 5'b00000);
    fflags_wen = 1'b0;
    drive_push(32'h88888888, 5'd10, 5'b00001);
    step();
    ex2_inst_wb  = 1'b0;
    fflags_wen   = 1'b1;
    fflags_wdata = 5'b01000;
    step();
    fflags_wen = 1'b0;
    check("t5_csr_q", fflags, 5'b01000);
    ack = 1'b1;
    step();
    check("t5_q_fl", fflags, 5'b01001);
    check("t5_empty", empty, 1'b1);

    // 6: random traffic honouring stall, against a queue model
    fflags_wen   = 1'b1;
    fflags_wdata = 5'd0;
    ack          = 1'b0;
    step();
    fflags_wen = 1'b0;
    fl_model   = 5'd0;
    for (int i = 0; i < 10000; i++) begin
      check("r_vld", vld, (q.size() != 0));
      if (q.size() != 0) check("r_head", {wb_reg, wb_data}, {q[0].dst, q[0].data});
      ex2_inst_wb = ~stall & ($urandom_range(0, 1) == 1);
      ack         = ($urandom_range(0, 1) == 1);
      ex2_data    = $urandom;
      ex2_dst     = 5'($urandom);
      ex2_fflags  = 5'($urandom);
      if (ack && q.size() != 0) begin
        fl_model = fl_model | q[0].fl;
        void'(q.pop_front());
      end
      if (ex2_inst_wb) q.push_back('{data: ex2_data, dst: ex2_dst, fl: ex2_fflags});
      step();
    end
    ex2_inst_wb = 1'b0;
    check("r_fflags", fflags,  fl_model);
    check("r_ovf",    ovf_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
